move_sequencer: RTL and testbench

Instruction-driven transfer master for the register bank. Accepts 16-bit move instructions over a valid/ready stream and turns them into the register bank's `from_addr`/`to_addr`/`enable` transfer cycles. It also drives `input_reg` for load-immediate. It sits between instruction fetch and `reg_bank`, replacing hand-driven testbench stimulus with a real issuing agent.

---
 rtl/move_sequencer_if.sv | 40 ++++
 rtl/move_sequencer.sv | 153 +++++++++++++++
 tb/tb_move_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/move_sequencer_if.sv
// Instruction stream and register-bank transfer bus for move_sequencer.
// master = the sequencer itself, slave = fetch / register-bank side.
interface move_sequencer_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        hold;
  logic [3:0]  from_addr;
  logic [3:0]  to_addr;
  logic        enable;
  logic [15:0] input_reg;
  logic        halted;
  logic        illegal;

  modport master (
    input  instr_valid,
    input  instr,
    input  hold,
    output instr_ready,
    output from_addr,
    output to_addr,
    output enable,
    output input_reg,
    output halted,
    output illegal
  );

  modport slave (
    output instr_valid,
    output instr,
    output hold,
    input  instr_ready,
    input  from_addr,
    input  to_addr,
    input  enable,
    input  input_reg,
    input  halted,
    input  illegal
  );
endinterface

// File: rtl/move_sequencer.sv
// Instruction-driven transfer master: decodes MOV/LDI/BLK/HALT words into
// register-bank from_addr/to_addr/enable cycles and drives the immediate.
module move_sequencer #(
  parameter logic [3:0] INPUT_SRC = 4'h0
) (
  input logic           clk,
  input logic           rst_n,
  move_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    FETCH,
    ISSUE,
    IMM,
    BLOCK,
    HALT
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_MOV  = 4'd1;
  localparam logic [3:0] OP_LDI  = 4'd2;
  localparam logic [3:0] OP_BLK  = 4'd3;
  localparam logic [3:0] OP_HALT = 4'd4;

  state_t      state;
  logic        ready_q;
  logic        enable_q;
  logic [3:0]  from_q;
  logic [3:0]  to_q;
  logic [15:0] imm_q;
  logic        halted_q;
  logic        illegal_q;
  logic [3:0]  ldi_dst;
  logic [3:0]  blk_arg;
  logic [3:0]  blk_cnt;

  logic [3:0]  opcode;
  logic [3:0]  src;
  logic [3:0]  dst;
  logic [3:0]  arg;
  logic        accept;

  assign opcode = bus.instr[15:12];
  assign src    = bus.instr[11:8];
  assign dst    = bus.instr[7:4];
  assign arg    = bus.instr[3:0];

  // hold qualifies the registered ready/enable so that a held cycle can
  // neither complete a handshake nor perform a transfer.
  assign accept          = bus.instr_valid && ready_q && !bus.hold;
  assign bus.instr_ready = ready_q && !bus.hold;
  assign bus.enable      = enable_q && !bus.hold;
  assign bus.from_addr   = from_q;
  assign bus.to_addr     = to_q;
  assign bus.input_reg   = imm_q;
  assign bus.halted      = halted_q;
  assign bus.illegal     = illegal_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FETCH;
      ready_q   <= 1'b0;
      enable_q  <= 1'b0;
      from_q    <= 4'h0;
      to_q      <= 4'h0;
      imm_q     <= 16'h0000;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      ldi_dst   <= 4'h0;
      blk_arg   <= 4'h0;
      blk_cnt   <= 4'h0;
    end else begin
      illegal_q <= 1'b0;
      // Under hold everything is frozen so the pending transfer is replayed
      // unchanged once hold drops.
      if (!bus.hold || state == HALT) begin
        case (state)
          FETCH: begin
            ready_q <= 1'b1;
            if (accept) begin
              case (opcode)
                OP_NOP: begin
                end
                OP_MOV: begin
                  state    <= ISSUE;
                  from_q   <= src;
                  to_q     <= dst;
                  enable_q <= 1'b1;
                  ready_q  <= 1'b0;
                end
                OP_LDI: begin
                  state   <= IMM;
                  ldi_dst <= dst;
                end
                OP_BLK: begin
                  state    <= BLOCK;
                  from_q   <= src;
                  to_q     <= dst;
                  blk_arg  <= arg;
                  blk_cnt  <= 4'h0;
                  enable_q <= 1'b1;
                  ready_q  <= 1'b0;
                end
                OP_HALT: begin
                  state    <= HALT;
                  halted_q <= 1'b1;
                  ready_q  <= 1'b0;
                end
                default: illegal_q <= 1'b1;
              endcase
            end
          end
          IMM: begin
            if (accept) begin
              state    <= ISSUE;
              imm_q    <= bus.instr;
              from_q   <= INPUT_SRC;
              to_q     <= ldi_dst;
              enable_q <= 1'b1;
              ready_q  <= 1'b0;
            end
          end
          ISSUE: begin
            state    <= FETCH;
            enable_q <= 1'b0;
            ready_q  <= 1'b1;
          end
          BLOCK: begin
            if (blk_cnt == blk_arg) begin
              state    <= FETCH;
              enable_q <= 1'b0;
              ready_q  <= 1'b1;
            end else begin
              blk_cnt <= blk_cnt + 4'd1;
              from_q  <= from_q + 4'd1;
              to_q    <= to_q + 4'd1;
            end
          end
          HALT: begin
            enable_q <= 1'b0;
            ready_q  <= 1'b0;
          end
          default: begin
            state    <= FETCH;
            enable_q <= 1'b0;
            ready_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Directed, table-driven bench for move_sequencer: each record gives the
// inputs for one cycle and the outputs expected during that same cycle.
module tb_move_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;

  move_sequencer_if bus ();

  move_sequencer #(.INPUT_SRC(4'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        valid;
    logic [15:0] instr;
    logic        hold;
    logic        chk;
    logic        ready;
    logic        en;
    logic [3:0]  from_a;
    logic [3:0]  to_a;
    logic [15:0] inp;
    logic        ill;
    logic        halt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic v, input logic [15:0] ins,
                              input logic h, input logic c, input logic rdy,
                              input logic en, input logic [3:0] fa, input logic [3:0] ta,
                              input logic [15:0] inp, input logic ill, input logic hl);
    vec_t x;
    x.rst_n = r;   x.valid = v;   x.instr = ins; x.hold = h;  x.chk = c;
    x.ready = rdy; x.en = en;     x.from_a = fa; x.to_a = ta; x.inp = inp;
    x.ill = ill;   x.halt = hl;
    return x;
  endfunction

  task automatic checkField(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL cycle %0d %s got %h want %h", cyc, name, got, want);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    cyc++;
    rst_n           = v.rst_n;
    bus.instr_valid = v.valid;
    bus.instr       = v.instr;
    bus.hold        = v.hold;
  endtask

  task automatic checkOutput(input vec_t v);
    checkField("instr_ready", {15'd0, bus.instr_ready}, {15'd0, v.ready});
    checkField("enable",      {15'd0, bus.enable},      {15'd0, v.en});
    checkField("from_addr",   {12'd0, bus.from_addr},   {12'd0, v.from_a});
    checkField("to_addr",     {12'd0, bus.to_addr},     {12'd0, v.to_a});
    checkField("input_reg",   bus.input_reg,            v.inp);
    checkField("illegal",     {15'd0, bus.illegal},     {15'd0, v.ill});
    checkField("halted",      {15'd0, bus.halted},      {15'd0, v.halt});
  endtask

  task automatic runVec(input vec_t v);
    applyStimulus(v);
    @(negedge clk);
    if (v.chk) checkOutput(v);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = -1;
    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0000;
    bus.hold        = 1'b0;

    // Reset, MOV A->B, LDI C <- 1, BLK E..0 -> 1..3 with wrap
    tbl.push_back(mk(0,0,16'h0000,0, 0, 0,0,4'h0,4'h0,16'h0000,0,0));
    tbl.push_back(mk(0,0,16'h0000,0, 1, 0,0,4'h0,4'h0,16'h0000,0,0));
    tbl.push_back(mk(1,0,16'h0000,0, 1, 0,0,4'h0,4'h0,16'h0000,0,0));
    tbl.push_back(mk(1,1,16'h1AB0,0, 1, 1,0,4'h0,4'h0,16'h0000,0,0));
    tbl.push_back(mk(1,0,16'h0000,0, 1, 0,1,4'hA,4'hB,16'h0000,0,0));
    tbl.push_back(mk(1,1,16'h20C0,0, 1, 1,0,4'hA,4'hB,16'h0000,0,0));
    tbl.push_back(mk(1,1,16'h0001,0, 1, 1,0,4'hA,4'hB,16'h0000,0,0));
    tbl.push_back(mk(1,0,16'h0000,0, 1, 0,1,4'h0,4'hC,16'h0001,0,0));
    tbl.push_back(mk(1,1,16'h3E12,0, 1, 1,0,4'h0,4'hC,16'h0001,0,0));
    tbl.push_back(mk(1,0,16'h0000,0, 1, 0,1,4'hE,4'h1,16'h0001,0,0));
    tbl.push_back(mk(1,0,16'h0000,0, 1, 0,1,4'hF,4'h2,16'h0001,0,0));
    tbl.push_back(mk(1,0,16'h0000,0, 1, 0,1,4'h0,4'h3,16'h0001,0,0));
    // BLK 4..7 -> 5..8 with hold for two cycles after the second transfer
    tbl.push_back(mk(1,1,16'h3453,0, 1, 1,0,4'h0,4'h3,16'h0001,0,0));
    tbl.push_back(mk(1,0,16'h0000,0, 1, 0,1,4'h4,4'h5,16'h0001,0,0));
    tbl.push_back(mk(1,0,16'h0000,0, 1, 0,1,4'h5,4'h6,16'h0001,0,0));
    tbl.push_back(mk(1,0,16'h0000,1, 1, 0,0,4'h6,4'h7,16'h0001,0,0));
    tbl.push_back(mk(1,0,16'h0000,1, 1, 0,0,4'h6,4'h7,16'h0001,0,0));
    tbl.push_back(mk(1,0,16'h0000,0, 1, 0,1,4'h6,4'h7,16'h0001,0,0));
    tbl.push_back(mk(1,0,16'h0000,0, 1, 0,1,4'h7,4'h8,16'h0001,0,0));
    // Illegal opcode 7, HALT, then a MOV that must never be taken
    tbl.push_back(mk(1,1,16'h7000,0, 1, 1,0,4'h7,4'h8,16'h0001,0,0));
    tbl.push_back(mk(1,1,16'h4000,0, 1, 1,0,4'h7,4'h8,16'h0001,1,0));
    tbl.push_back(mk(1,1,16'h1AB0,0, 1, 0,0,4'h7,4'h8,16'h0001,0,1));
    tbl.push_back(mk(1,1,16'h1AB0,1, 1, 0,0,4'h7,4'h8,16'h0001,0,1));
    tbl.push_back(mk(0,0,16'h0000,0, 1, 0,0,4'h7,4'h8,16'h0001,0,1));
    // Reset during the second transfer of BLK 1..6 -> 2..7, then a fresh MOV
    tbl.push_back(mk(1,0,16'h0000,0, 1, 0,0,4'h0,4'h0,16'h0000,0,0));
    tbl.push_back(mk(1,1,16'h3125,0, 1, 1,0,4'h0,4'h0,16'h0000,0,0));
    tbl.push_back(mk(1,0,16'h0000,0, 1, 0,1,4'h1,4'h2,16'h0000,0,0));
    tbl.push_back(mk(0,0,16'h0000,0, 1, 0,1,4'h2,4'h3,16'h0000,0,0));
    tbl.push_back(mk(1,0,16'h0000,0, 1, 0,0,4'h0,4'h0,16'h0000,0,0));
    tbl.push_back(mk(1,1,16'h1AB0,0, 1, 1,0,4'h0,4'h0,16'h0000,0,0));
    tbl.push_back(mk(1,0,16'h0000,0, 1, 0,1,4'hA,4'hB,16'h0000,0,0));
    tbl.push_back(mk(1,0,16'h0000,0, 1, 1,0,4'hA,4'hB,16'h0000,0,0));

    foreach (tbl[i]) runVec(tbl[i]);

    // Slow immediate: IMM waits with valid low, then a reset discards it
    runVec(mk(1,1,16'h2050,0, 1, 1,0,4'hA,4'hB,16'h0000,0,0));
    runVec(mk(1,0,16'h0000,0, 1, 1,0,4'hA,4'hB,16'h0000,0,0));
    runVec(mk(1,0,16'h0000,0, 1, 1,0,4'hA,4'hB,16'h0000,0,0));
    runVec(mk(0,1,16'h1234,0, 1, 1,0,4'hA,4'hB,16'h0000,0,0));
    runVec(mk(1,0,16'h0000,0, 1, 0,0,4'h0,4'h0,16'h0000,0,0));
    runVec(mk(1,0,16'h0000,0, 1, 1,0,4'h0,4'h0,16'h0000,0,0));

    // Immediate word with a non-zero opcode field is loaded as plain data
    runVec(mk(1,1,16'h2060,0, 1, 1,0,4'h0,4'h0,16'h0000,0,0));
    runVec(mk(1,1,16'hBEEF,0, 1, 1,0,4'h0,4'h0,16'h0000,0,0));
    runVec(mk(1,0,16'h0000,0, 1, 0,1,4'h0,4'h6,16'hBEEF,0,0));
    runVec(mk(1,0,16'h0000,0, 1, 1,0,4'h0,4'h6,16'hBEEF,0,0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
